// File: rtl/rol_seq_shifter.sv
// rol_seq_shifter: sequential rotate-left unit with a valid/ready handshake on each side.
//   A request (a_i, amt_i) is accepted in IDLE. The operand is then rotated left
//   step by step in SHIFT until the step counter reaches zero. The result is held
//   in DONE until the downstream side accepts it.
// Configuration macro: ROL_STEP2_EN. When it is defined, SHIFT rotates by 2 bits
//   per cycle while the counter is >= 2, and by 1 bit otherwise. The result is
//   the same; only the latency changes.
// Ports:
//   clk_i    in   clock, rising-edge active
//   rst_i    in   synchronous active-high reset
//   valid_i  in   request valid (qualifies a_i, amt_i)
//   ready_o  out  block can accept a request (IDLE)
//   a_i      in   [WIDTH-1:0] operand
//   amt_i    in   [AMT_W-1:0] rotate-left amount
//   valid_o  out  result valid on y_o (DONE)
//   ready_i  in   downstream accepts the result
//   y_o      out  [WIDTH-1:0] rotated result, registered
// WIDTH must be a power of two and at least 2.

module rol_seq_shifter #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [AMT_W-1:0] amt_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] y_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic [AMT_W-1:0] r_cnt;
   logic             r_valid;
   logic             r_ready;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_data_nx;
   logic [AMT_W-1:0] w_cnt_nx;

   // Rotate left by n using a doubled copy of the word. This also works for WIDTH=2.
   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d, input int unsigned n);
      logic [2*WIDTH-1:0] t;
      t = {d, d} << n;
      return t[2*WIDTH-1:WIDTH];
   endfunction

`ifdef ROL_STEP2_EN
   localparam int unsigned CNT_X_W = AMT_W + 1;
   // Zero-extended so that the ">= 2" compare is legal when AMT_W is 1.
   logic [CNT_X_W-1:0] w_cnt_x;
   assign w_cnt_x = {1'b0, r_cnt};
`endif

   // Next-state and datapath update
   always_comb begin
      w_state_nx = r_state;
      w_data_nx  = r_data;
      w_cnt_nx   = r_cnt;
      case (r_state)
         IDLE: begin
            if (valid_i) begin
               w_data_nx  = a_i;
               w_cnt_nx   = amt_i;
               w_state_nx = (amt_i == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
`ifdef ROL_STEP2_EN
            if (w_cnt_x >= CNT_X_W'(2)) begin
               w_data_nx = rotl(r_data, 2);
               w_cnt_nx  = r_cnt - AMT_W'(2);
            end else begin
               w_data_nx = rotl(r_data, 1);
               w_cnt_nx  = r_cnt - AMT_W'(1);
            end
`else
            w_data_nx = rotl(r_data, 1);
            w_cnt_nx  = r_cnt - AMT_W'(1);
`endif
            if (w_cnt_nx == '0) begin
               w_state_nx = DONE;
            end
         end
         DONE: begin
            if (ready_i) begin
               w_state_nx = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // State and datapath registers. Handshake outputs are registered from the next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_data  <= w_data_nx;
         r_cnt   <= w_cnt_nx;
         r_valid <= (w_state_nx == DONE);
         r_ready <= (w_state_nx == IDLE);
      end
   end

   assign ready_o = r_ready;
   assign valid_o = r_valid;
   assign y_o     = r_data;

endmodule

// File: doc/rol_seq_shifter.md
ROL_SEQ_SHIFTER -- requirements
Module: rol_seq_shifter

Interface
REQ-001 Parameter: WIDTH, default 4, data width in bits; SHALL be a power of two, >= 2.
REQ-002 Derived constant: AMT_W = log2(WIDTH), the rotate-amount width (2 at default).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  request valid; a_i and amt_i qualified by it.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 a_i  input  WIDTH  operand to rotate left.
REQ-008 amt_i  input  AMT_W  rotate-left amount, 0 to WIDTH-1.
REQ-009 valid_o  output  1  result valid on y_o.
REQ-010 ready_i  input  1  downstream accepts the result.
REQ-011 y_o  output  WIDTH  rotated result, registered.

Function
REQ-012 SHALL perform rotate-left: y = {a[WIDTH-1-amt:0], a[WIDTH-1:WIDTH-amt]}; amt=0 returns a unchanged.
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE: ready_o=1, valid_o=0; when valid_i=1 at a rising edge, SHALL capture a_i into the data register and amt_i into the step counter.
REQ-015 Accept with amt_i=0 SHALL go IDLE->DONE; accept with amt_i>0 SHALL go IDLE->SHIFT.
REQ-016 SHIFT: each cycle, SHALL rotate the data register left by one step and decrement the counter; on the step that brings the counter to 0, SHALL go SHIFT->DONE.
REQ-017 Latency: request accepted in cycle T SHALL give valid_o=1 in cycle T+1+amt (step-1 mode).
REQ-018 DONE: valid_o=1, y_o stable; SHALL hold until ready_i=1 at a rising edge, then go DONE->IDLE.
REQ-019 ready_o SHALL be 0 in SHIFT and DONE; valid_i there SHALL be ignored, with no capture.
REQ-020 No back-to-back overlap: the next accept SHALL occur no earlier than the cycle after the DONE->IDLE handshake.
REQ-021 y_o SHALL retain the last result in IDLE; consumers SHALL qualify y_o with valid_o.
REQ-022 a_i and amt_i changes after capture SHALL NOT affect the operation in progress.

Reset
REQ-023 rst_i=1 at a rising edge SHALL force IDLE, y_o=0, counter=0, valid_o=0, ready_o=1.
REQ-024 Reset SHALL take priority over all FSM transitions.
REQ-025 Reset in SHIFT or DONE SHALL discard the operation, and no valid_o SHALL follow.
REQ-026 With rst_i=1 and valid_i=1 in the same cycle, the request SHALL NOT be accepted.

Configuration
REQ-027 Macro ROL_STEP2_EN defined: SHIFT SHALL rotate 2 bits per cycle while counter >= 2, else 1 bit.
REQ-028 With ROL_STEP2_EN defined, latency SHALL be 1+ceil(amt/2) cycles, and result values SHALL be identical to step-1 mode.
REQ-029 Macro undefined: 1 bit per cycle; latency per REQ-017.

Verification
REQ-030 After rst_i pulse: ready_o=1, valid_o=0, y_o=4'b0000.
REQ-031 a_i=4'b1001, amt_i=1, ready_i=1 -> valid_o in T+2, y_o=4'b0011, then IDLE.
REQ-032 a_i=4'b1011, amt_i=3, ready_i=0 for 5 cycles after valid_o -> y_o=4'b1101 held stable, valid_o held; ready_o=0 throughout.
REQ-033 a_i=4'b0110, amt_i=0 -> valid_o in T+1, y_o=4'b0110; a second valid_i while busy is ignored.
REQ-034 rst_i asserted during SHIFT of a_i=4'b0001, amt_i=3 -> next cycle IDLE, y_o=0, no valid_o pulse.
REQ-035 WIDTH=8, a_i=8'h81, amt_i=7 -> y_o=8'hC0; latency 8 cycles, or 5 with ROL_STEP2_EN.
